// File: rtl/bcd_to_binary_if.sv
// Request/result bundle for the BCD-to-binary converter.
// master drives the request, slave (the converter) returns the result.
interface bcd_to_binary_if #(
   parameter int DIGITS = 8,
   parameter int W      = 32
);
   logic                  switch;
   logic                  i_Start;
   logic [4*DIGITS-1:0]   i_BCD;
   logic [W-1:0]          o_Binary;
   logic                  o_DV;
   logic                  o_Error;
   logic                  o_Busy;

   modport master (
      output switch, i_Start, i_BCD,
      input  o_Binary, o_DV, o_Error, o_Busy
   );

   modport slave (
      input  switch, i_Start, i_BCD,
      output o_Binary, o_DV, o_Error, o_Busy
   );
endinterface

// File: rtl/bcd_to_binary.sv
// Packed BCD to binary, one digit per clock, MSD first.
// Hex mode passes the input straight through.
module bcd_to_binary #(
   parameter int DIGITS = 8,
   parameter int W      = 32
) (
   input  logic            clock,
   input  logic            reset_n,
   bcd_to_binary_if.slave  bus
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   acc, acc_nxt;
   logic [BW-1:0]  sr, sr_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           err, err_nxt;
   logic           mode, mode_nxt;
   logic [W-1:0]   bin, bin_nxt;
   logic           dv, dv_nxt;
   logic           error, error_nxt;
   logic [3:0]     d;

   assign d = sr[BW-1 -: 4];

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      sr_nxt    = sr;
      cnt_nxt   = cnt;
      err_nxt   = err;
      mode_nxt  = mode;
      bin_nxt   = bin;
      error_nxt = error;
      dv_nxt    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.i_Start) begin
               sr_nxt   = bus.i_BCD;
               mode_nxt = bus.switch;
               acc_nxt  = '0;
               cnt_nxt  = '0;
               err_nxt  = 1'b0;
               if (bus.switch) begin
                  state_nxt = RUN;
               end else begin
                  acc_nxt   = W'(bus.i_BCD);
                  state_nxt = DONE;
               end
            end
         end
         RUN: begin
            // acc*10 + d; out-of-range digits still add raw
            acc_nxt = (acc << 3) + (acc << 1) + W'(d);
            sr_nxt  = sr << 4;
            cnt_nxt = cnt + 1'b1;
            if (d > 4'd9)
               err_nxt = 1'b1;
            if (cnt == CW'(DIGITS - 1))
               state_nxt = DONE;
         end
         DONE: begin
            bin_nxt   = acc;
            error_nxt = err & mode;
            dv_nxt    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
         acc   <= '0;
         sr    <= '0;
         cnt   <= '0;
         err   <= 1'b0;
         mode  <= 1'b0;
         bin   <= '0;
         dv    <= 1'b0;
         error <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         sr    <= sr_nxt;
         cnt   <= cnt_nxt;
         err   <= err_nxt;
         mode  <= mode_nxt;
         bin   <= bin_nxt;
         dv    <= dv_nxt;
         error <= error_nxt;
      end
   end

   assign bus.o_Binary = bin;
   assign bus.o_DV     = dv;
   assign bus.o_Error  = error;
   assign bus.o_Busy   = (state != IDLE);
endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: random and directed
// conversions checked against a decimal arithmetic model.
module tb_bcd_to_binary;
   localparam int DIGITS = 8;
   localparam int W      = 32;
   localparam int BW     = 4 * DIGITS;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   always #10 clock = ~clock;

   bcd_to_binary_if #(.DIGITS(DIGITS), .W(W)) bus ();

   bcd_to_binary #(.DIGITS(DIGITS), .W(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [W-1:0] bin;
      logic         err;
      int           cyc;
   } exp_t;

   exp_t         sb[$];
   exp_t         got;
   int           cyc    = 0;
   int           n_cmp  = 0;
   int           n_bad  = 0;
   logic [W-1:0] last_bin = '0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: decimal value of the digit string, wrapped to W bits
   function automatic exp_t model(logic sw, logic [BW-1:0] bcd, int c);
      exp_t e;
      logic [3:0] dg;
      e.bin = '0;
      e.err = 1'b0;
      if (!sw) begin
         e.bin = W'(bcd);
         e.cyc = c + 1;
      end else begin
         for (int i = DIGITS - 1; i >= 0; i--) begin
            dg = bcd[4*i +: 4];
            e.bin = W'(e.bin * 10 + W'(dg));
            if (dg > 4'd9) e.err = 1'b1;
         end
         e.cyc = c + DIGITS + 1;
      end
      return e;
   endfunction

   always @(negedge clock) begin
      if (bus.o_DV) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_dv: got o_Binary %0h want no pulse (cycle %0d)",
                     bus.o_Binary, cyc);
         end else begin
            got = sb.pop_front();
            check("binary", 64'(bus.o_Binary), 64'(got.bin));
            check("error", 64'(bus.o_Error), 64'(got.err));
            check("latency", 64'(cyc), 64'(got.cyc));
            last_bin = got.bin;
         end
      end
   end

   task automatic start_one(logic sw, logic [BW-1:0] bcd);
      @(negedge clock);
      bus.switch  = sw;
      bus.i_BCD   = bcd;
      bus.i_Start = 1'b1;
      sb.push_back(model(sw, bcd, cyc + 1));
      @(negedge clock);
      bus.i_Start = 1'b0;
   endtask

   task automatic wait_idle(int want_busy);
      int nb = 0;
      int t  = 0;
      while (bus.o_Busy && t < 100) begin
         nb++;
         t++;
         @(negedge clock);
      end
      if (t >= 100) begin
         n_cmp++;
         n_bad++;
         $display("FAIL busy_timeout: got busy after %0d cycles want idle", t);
      end
      if (want_busy >= 0)
         check("busy_cycles", 64'(nb), 64'(want_busy));
      @(negedge clock);
      check("held_binary", 64'(bus.o_Binary), 64'(last_bin));
   endtask

   function automatic logic [BW-1:0] rand_bcd();
      logic [BW-1:0] v;
      if ($urandom_range(0, 3) == 0) begin
         v = BW'($urandom);
      end else begin
         v = '0;
         for (int i = 0; i < DIGITS; i++)
            v[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      return v;
   endfunction

   initial begin
      #1ms;
      $display("FAIL watchdog: got no finish want finish within 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BW-1:0] v;
      logic          sw;
      int            c0;
      bus.switch  = 1'b1;
      bus.i_Start = 1'b0;
      bus.i_BCD   = '0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      check("rst_binary", 64'(bus.o_Binary), 64'd0);
      check("rst_dv", 64'(bus.o_DV), 64'd0);
      check("rst_error", 64'(bus.o_Error), 64'd0);
      check("rst_busy", 64'(bus.o_Busy), 64'd0);

      start_one(1'b1, 32'h0000_1234);
      wait_idle(DIGITS + 1);
      start_one(1'b1, 32'h9999_9999);
      wait_idle(DIGITS + 1);
      start_one(1'b1, 32'h0000_0000);
      wait_idle(DIGITS + 1);
      start_one(1'b0, 32'hDEAD_BEEF);
      wait_idle(1);
      start_one(1'b1, 32'h0000_001A);
      wait_idle(DIGITS + 1);
      start_one(1'b1, 32'h0000_0007);
      wait_idle(DIGITS + 1);

      // Starts and input changes while running must not disturb it
      start_one(1'b1, 32'h0000_4321);
      repeat (2) begin
         @(negedge clock);
         bus.i_Start = 1'b1;
         bus.switch  = 1'b0;
         bus.i_BCD   = BW'($urandom);
         @(negedge clock);
         bus.i_Start = 1'b0;
      end
      wait_idle(-1);

      // Held start: restart every DIGITS+2 clocks
      @(negedge clock);
      bus.switch  = 1'b1;
      bus.i_BCD   = 32'h0031_4159;
      bus.i_Start = 1'b1;
      c0 = cyc + 1;
      for (int k = 0; k < 3; k++)
         sb.push_back(model(1'b1, 32'h0031_4159, c0 + k * (DIGITS + 2)));
      repeat (2 * (DIGITS + 2) + 1) @(negedge clock);
      bus.i_Start = 1'b0;
      wait_idle(-1);

      // Reset in the 4th RUN cycle aborts without a result
      @(negedge clock);
      bus.switch  = 1'b1;
      bus.i_BCD   = 32'h0000_5678;
      bus.i_Start = 1'b1;
      @(negedge clock);
      bus.i_Start = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      check("abort_binary", 64'(bus.o_Binary), 64'd0);
      check("abort_dv", 64'(bus.o_DV), 64'd0);
      check("abort_error", 64'(bus.o_Error), 64'd0);
      check("abort_busy", 64'(bus.o_Busy), 64'd0);
      last_bin = '0;
      repeat (12) @(negedge clock);
      check("abort_binary_late", 64'(bus.o_Binary), 64'd0);
      start_one(1'b1, 32'h0000_5678);
      wait_idle(DIGITS + 1);

      for (int i = 0; i < 40; i++) begin
         sw = 1'($urandom_range(0, 1));
         v  = rand_bcd();
         start_one(sw, v);
         wait_idle(sw ? DIGITS + 1 : 1);
      end

      repeat (5) @(negedge clock);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
